// File: rtl/branch_train_queue_pkg.sv
// Shared branch-predictor types and default sizes for the
// in-flight branch training queue.
package branch_train_queue_pkg;

    localparam int BTQ_DEPTH  = 8;
    localparam int BTQ_PC_W   = 7;
    localparam int BTQ_HIST_W = 7;

    typedef struct packed {
        logic                  valid;
        logic                  resolved;
        logic                  pred_taken;
        logic                  taken;
        logic [BTQ_PC_W-1:0]   pc;
        logic [BTQ_HIST_W-1:0] history;
    } btq_entry_t;

endpackage

// File: rtl/branch_train_queue.sv
// In-order branch training queue: records predictions, accepts
// out-of-order resolutions and retires to the gshare train port.
module branch_train_queue
    import branch_train_queue_pkg::*;
#(
    parameter int DEPTH  = BTQ_DEPTH,
    parameter int PC_W   = BTQ_PC_W,
    parameter int HIST_W = BTQ_HIST_W,
    localparam int TW    = $clog2(DEPTH),
    localparam int CW    = TW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic [HIST_W-1:0] alloc_history,
    input  logic              alloc_pred_taken,
    output logic [TW-1:0]     alloc_tag,
    input  logic              resolve_valid,
    input  logic [TW-1:0]     resolve_tag,
    input  logic              resolve_taken,
    output logic              train_valid,
    output logic              train_taken,
    output logic              train_mispredicted,
    output logic [PC_W-1:0]   train_pc,
    output logic [HIST_W-1:0] train_history,
    output logic [CW-1:0]     count
);

    btq_entry_t        q [DEPTH];
    logic [TW-1:0]     head;
    logic [TW-1:0]     tail;
    btq_entry_t        head_e;
    logic              pop;
    logic              squash;
    logic              alloc_fire;
    logic              res_ok;

    assign head_e      = q[head];
    assign pop         = head_e.valid && head_e.resolved;
    assign squash      = pop && (head_e.taken != head_e.pred_taken);
    assign alloc_ready = (count != CW'(DEPTH)) && !squash;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail;
    assign res_ok      = resolve_valid
                      && q[resolve_tag].valid
                      && !q[resolve_tag].resolved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            train_valid        <= 1'b0;
            train_taken        <= 1'b0;
            train_mispredicted <= 1'b0;
            train_pc           <= '0;
            train_history      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            train_valid <= pop;
            if (pop) begin
                train_taken        <= head_e.taken;
                train_mispredicted <= squash;
                train_pc           <= head_e.pc;
                train_history      <= head_e.history;
            end

            if (res_ok) begin
                q[resolve_tag].resolved <= 1'b1;
                q[resolve_tag].taken    <= resolve_taken;
            end

            if (alloc_fire) begin
                q[tail] <= '{
                    valid:      1'b1,
                    resolved:   1'b0,
                    pred_taken: alloc_pred_taken,
                    taken:      1'b0,
                    pc:         alloc_pc,
                    history:    alloc_history
                };
            end

            if (pop) begin
                q[head].valid <= 1'b0;
            end

            // a wrong-path head kills everything younger, including
            // any resolve landing on those slots this cycle
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    q[i].valid <= 1'b0;
                end
            end

            if (squash) begin
                head  <= head + 1'b1;
                tail  <= head + 1'b1;
                count <= '0;
            end else begin
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (alloc_fire) begin
                    tail <= tail + 1'b1;
                end
                unique case ({alloc_fire, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_train_queue.sv
// Randomized and directed bench for branch_train_queue against a
// queue-based reference model of in-flight branches.
module tb_branch_train_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [6:0] alloc_pc = '0;
    logic [6:0] alloc_history = '0;
    logic       alloc_pred_taken = 1'b0;
    logic [2:0] alloc_tag;
    logic       resolve_valid = 1'b0;
    logic [2:0] resolve_tag = '0;
    logic       resolve_taken = 1'b0;
    logic       train_valid;
    logic       train_taken;
    logic       train_mispredicted;
    logic [6:0] train_pc;
    logic [6:0] train_history;
    logic [3:0] count;

    branch_train_queue dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_pc           (alloc_pc),
        .alloc_history      (alloc_history),
        .alloc_pred_taken   (alloc_pred_taken),
        .alloc_tag          (alloc_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_pc           (train_pc),
        .train_history      (train_history),
        .count              (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [6:0] pc;
        logic [6:0] hist;
        bit         pred;
        bit         res;
        bit         tk;
    } ment_t;

    ment_t      mq[$];
    int         m_head;
    int         m_tail;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         last_acc;
    int         last_tag;
    bit         last_tv;
    logic [6:0] last_pc;
    bit         last_mis;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        resolve_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic step(input bit av, input logic [6:0] pc,
                        input logic [6:0] hist, input bit pred,
                        input bit rv, input int rtag, input bit rt);
        bit    exp_ready;
        bit    pop;
        bit    mis;
        ment_t h;
        @(negedge clk);
        alloc_valid = av;
        alloc_pc = pc;
        alloc_history = hist;
        alloc_pred_taken = pred;
        resolve_valid = rv;
        resolve_tag = 3'(rtag);
        resolve_taken = rt;
        #1;
        exp_ready = mq.size() < 8;
        if (mq.size() > 0 && mq[0].res && mq[0].tk != mq[0].pred)
            exp_ready = 1'b0;
        n_checks++;
        if (alloc_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL alloc_ready: got %b want %b",
                     alloc_ready, exp_ready);
        end
        if (exp_ready) begin
            n_checks++;
            if (alloc_tag !== 3'(m_tail)) begin
                n_fail++;
                $display("FAIL alloc_tag: got %0d want %0d",
                         alloc_tag, m_tail);
            end
        end
        last_acc = av && exp_ready;
        last_tag = m_tail;
        pop = mq.size() > 0 && mq[0].res;
        mis = 1'b0;
        if (pop) begin
            h = mq[0];
            mis = h.tk != h.pred;
        end
        if (rv) begin
            foreach (mq[i]) begin
                if (mq[i].tag == rtag && !mq[i].res) begin
                    mq[i].res = 1'b1;
                    mq[i].tk = rt;
                end
            end
        end
        if (pop) begin
            if (mis) mq.delete();
            else void'(mq.pop_front());
            m_head = (m_head + 1) % 8;
            if (mis) m_tail = m_head;
        end
        if (last_acc) begin
            mq.push_back('{tag: m_tail, pc: pc, hist: hist,
                           pred: pred, res: 1'b0, tk: 1'b0});
            m_tail = (m_tail + 1) % 8;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (train_valid !== pop) begin
            n_fail++;
            $display("FAIL train_valid: got %b want %b",
                     train_valid, pop);
        end
        if (pop) begin
            n_checks++;
            if (train_pc !== h.pc || train_history !== h.hist
                || train_taken !== h.tk
                || train_mispredicted !== mis) begin
                n_fail++;
                $display("FAIL train_data: got pc=%h h=%h t=%b m=%b want pc=%h h=%h t=%b m=%b",
                         train_pc, train_history, train_taken,
                         train_mispredicted, h.pc, h.hist, h.tk, mis);
            end
        end
        n_checks++;
        if (count !== 4'(mq.size())) begin
            n_fail++;
            $display("FAIL count: got %0d want %0d", count, mq.size());
        end
        last_tv = train_valid;
        last_pc = train_pc;
        last_mis = train_mispredicted;
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (count !== 4'd0 || alloc_ready !== 1'b1 || train_valid !== 1'b0
            || alloc_tag !== 3'd0 || train_pc !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d rdy=%b tv=%b tag=%0d pc=%h want 0 1 0 0 0",
                     count, alloc_ready, train_valid, alloc_tag, train_pc);
        end
    endtask

    task automatic test_in_order();
        int t;
        do_reset();
        step(1, 7'h05, 7'h00, 1, 0, 0, 0);
        t = last_tag;
        step(0, '0, '0, 0, 1, t, 1);
        n_checks++;
        if (last_tv !== 1'b0) begin
            n_fail++;
            $display("FAIL in_order_early: got tv=%b want 0", last_tv);
        end
        idle();
        n_checks++;
        if (last_tv !== 1'b1 || last_pc !== 7'h05 || last_mis !== 1'b0
            || train_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL in_order_hit: got tv=%b pc=%h mis=%b want 1 05 0",
                     last_tv, last_pc, last_mis);
        end
    endtask

    task automatic test_out_of_order();
        logic [6:0] pcs[$];
        int         when[$];
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 7'(8'h10 + i), 7'(i), 1, 0, 0, 0);
        step(0, '0, '0, 0, 1, 2, 1);
        step(0, '0, '0, 0, 1, 1, 1);
        step(0, '0, '0, 0, 1, 0, 1);
        for (int c = 0; c < 5; c++) begin
            idle();
            if (last_tv) begin
                pcs.push_back(last_pc);
                when.push_back(c);
            end
        end
        n_checks++;
        if (pcs.size() != 3) begin
            n_fail++;
            $display("FAIL ooo_pulses: got %0d want 3", pcs.size());
        end else begin
            n_checks++;
            if (pcs[0] !== 7'h10 || pcs[1] !== 7'h11 || pcs[2] !== 7'h12
                || when[1] != when[0] + 1 || when[2] != when[1] + 1) begin
                n_fail++;
                $display("FAIL ooo_order: got %h %h %h at %0d %0d %0d want 10 11 12 consecutive",
                         pcs[0], pcs[1], pcs[2], when[0], when[1], when[2]);
            end
        end
    endtask

    task automatic test_squash();
        int pulses;
        do_reset();
        step(1, 7'h20, 7'h2a, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++)
            step(1, 7'(8'h20 + i), 7'($urandom), 1'($urandom), 0, 0, 0);
        step(0, '0, '0, 0, 1, 0, 1);
        step(1, 7'h7f, 7'h7f, 1, 0, 0, 0);
        n_checks++;
        if (last_tv !== 1'b1 || last_mis !== 1'b1 || last_pc !== 7'h20
            || count !== 4'd0) begin
            n_fail++;
            $display("FAIL squash_pulse: got tv=%b mis=%b pc=%h cnt=%0d want 1 1 20 0",
                     last_tv, last_mis, last_pc, count);
        end
        pulses = 0;
        for (int i = 1; i < 4; i++) begin
            step(0, '0, '0, 0, 1, i, 1);
            pulses += int'(last_tv);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            pulses += int'(last_tv);
        end
        n_checks++;
        if (pulses != 0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL squash_stale: got pulses=%0d cnt=%0d want 0 0",
                     pulses, count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 7'(8'h30 + i), 7'(i), 1, 0, 0, 0);
        n_checks++;
        if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_state: got rdy=%b cnt=%0d want 0 8",
                     alloc_ready, count);
        end
        step(1, 7'h55, 7'h55, 1, 0, 0, 0);
        n_checks++;
        if (last_acc || count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_ninth: got acc=%b cnt=%0d want 0 8",
                     last_acc, count);
        end
        step(0, '0, '0, 0, 1, 0, 1);
        idle();
        n_checks++;
        if (alloc_ready !== 1'b1 || count !== 4'd7 || last_pc !== 7'h30) begin
            n_fail++;
            $display("FAIL full_drain: got rdy=%b cnt=%0d pc=%h want 1 7 30",
                     alloc_ready, count, last_pc);
        end
    endtask

    task automatic test_wrap();
        int         t;
        int         bad;
        logic [6:0] pc;
        bit         p;
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            pc = 7'($urandom);
            p = 1'($urandom);
            step(1, pc, 7'($urandom), p, 0, 0, 0);
            t = last_tag;
            if (t != i % 8) bad++;
            step(0, '0, '0, 0, 1, t, p);
            idle();
            if (!last_tv || last_pc !== pc) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap: got %0d bad tags/pulses want 0", bad);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 7'($urandom), 7'($urandom),
                 1'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom));
        end
    endtask

    task automatic test_reset_midflight();
        int pulses;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 7'(8'h40 + i), 7'(i), 1, 0, 0, 0);
        step(0, '0, '0, 0, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        resolve_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || train_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: got cnt=%0d tv=%b want 0 0",
                     count, train_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_head = 0;
        m_tail = 0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            pulses += int'(last_tv);
        end
        n_checks++;
        if (pulses != 0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL midflight_after: got pulses=%0d cnt=%0d want 0 0",
                     pulses, count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        m_head = 0;
        m_tail = 0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_squash();
        test_full();
        test_wrap();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
